ipgu_win_sched: RTL and testbench
=================================

# ipgu_win_sched

Frame-level scheduler for the image pyramid generation unit. For each pyramid level, it raster-scans the window origins and issues each origin to the window fetch path over a valid/ready handshake. Between levels it commands the RAM1→RAM2 downscale copy and waits for it to finish. It sits between the top-level control unit (start/done) and the IPGU address/fetch datapath. Level sizes shrink by 4/5 per level until a level can no longer hold one window.

## Interface
Parameters:
- IMG_SIZE, 300: level-0 edge length in pixels (square image).
- WIN, 20: window edge length.
- STRIDE, 10: window step in x and y.
- ADDR_W, 9: width of coordinate and size fields.
- LVL_W, 4: width of the level index.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- start  in  1  one-cycle pulse that begins a frame; ignored while busy.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the frame completes.
- winVld  out  1  window origin valid.
- winRdy  in  1  fetch path accepts the origin; transfer occurs when winVld&winRdy.
- winX, winY  out  ADDR_W  window origin, in current-level coordinates.
- winLvl  out  LVL_W  current level index (0 = full resolution).
- winLvlLast  out  1  the presented window is the last one of its level.
- winFrmLast  out  1  the presented window is the last one of the frame.
- scaleReq  out  1  downscale request; held high until scaleAck.
- scaleAck  in  1  scaler accepted the request.
- scaleSrc, scaleDst  out  ADDR_W  source and destination level edge sizes; stable while scaleReq is high.
- scaleDone  in  1  one-cycle pulse when the scaler copy is complete.

## Operation
- States: IDLE, WIN, SCALE_REQ, SCALE_WAIT, FIN.
- IDLE: on start, set size S=IMG_SIZE, level=0, x=y=0.
  - If IMG_SIZE<WIN, go to FIN.
  - Otherwise go to WIN.
- WIN: present winVld with (x,y,level).
  - On each transfer, advance x+=STRIDE.
  - If x+STRIDE+WIN>S, set x=0 and advance y+=STRIDE.
  - The level ends when the next y fails the same test.
  - At level end, compute Snext=floor(4·S/5), exact and truncated, computed at ADDR_W+3 bits internally.
  - If Snext≥WIN, go to SCALE_REQ with scaleSrc=S and scaleDst=Snext. Otherwise go to FIN.
- SCALE_REQ: hold scaleReq high; on scaleAck go to SCALE_WAIT.
- SCALE_WAIT: on scaleDone, set S=Snext, level+=1, x=y=0, and go to WIN.
- FIN: pulse done for one cycle, clear busy, return to IDLE.
- Flag rules:
  - winLvlLast is high when the presented origin is the last of its level.
  - winFrmLast is high when winLvlLast is high and Snext<WIN.
- Stray inputs: scaleDone outside SCALE_WAIT, scaleAck outside SCALE_REQ, and winRdy while winVld is low are all ignored.
- Window count per level is (floor((S−WIN)/STRIDE)+1)². Windows that would not fit are dropped; there is no edge alignment.
- Default level sizes: 300, 240, 192, 153, 122, 97, 77, 61, 48, 38, 30, 24. That is 12 levels, with the last level index 11.

## Timing
- Reset: all outputs are 0, state is IDLE, and internal counters are 0. Reset mid-frame aborts immediately and emits no done.
- start accepted in cycle t: busy=1 and winVld=1 with origin (0,0,0) in cycle t+1.
- winVld stays high and winX/winY/winLvl/flags stay stable until the transfer. The next origin appears in the cycle after the transfer, so back-to-back throughput is 1 window per cycle.
- When the last window of a level transfers in cycle t:
  - scaleReq=1 in cycle t+1, or done=1 if no further level exists.
  - winVld=0 during SCALE_REQ and SCALE_WAIT.
- scaleAck in cycle t drops scaleReq in cycle t+1. scaleAck in the same cycle scaleReq rises is valid.
- scaleDone in cycle t gives winVld=1 with (0,0,level+1) in cycle t+1. scaleDone in the same cycle as scaleAck is ignored.
- IMG_SIZE<WIN: done pulses in cycle t+1 after start, with no windows and no scale.
- done and busy=0 occur in the same cycle. start in that done cycle is ignored; start is accepted from the next cycle.

## Test plan
- Parameters IMG_SIZE=40, WIN=20, STRIDE=10, winRdy=1, scaler acks and finishes 3 cycles after each request:
  - Expect 15 windows with level sizes 40/32/25/20 and per-level counts 9/4/1/1.
  - Expect 3 scale requests with (src,dst) = (40,32), (32,25), (25,20).
  - Expect the origin order for level 0 to be (0,0),(10,0),(20,0),(0,10),…,(20,20).
  - Expect winFrmLast only on window 15, then one done.
- Random winRdy backpressure (30% high) with the same parameters: winX/winY/winLvl are held stable while stalled; the transfer sequence is identical to the first test.
- Default parameters, full frame: 12 levels, final winLvl=11 with a single window (0,0) at size 24; 11 scale requests; level-0 count 841.
- IMG_SIZE=19: start → done in cycle t+1, winVld never asserts.
- Assert rst_n=0 for 1 cycle during SCALE_WAIT, then pulse scaleDone: outputs are all 0, no done, the late scaleDone is ignored, and a new start restarts at level 0 with (0,0).
- Pulse start while busy, and pulse scaleDone during WIN: neither has any effect on the sequence or the counts.

Source files
------------

// File: rtl/ipgu_win_sched.sv
// Pyramid window scheduler: raster-scans window origins per level, then runs the RAM1->RAM2 downscale between levels.
// Origins are issued over a valid/ready handshake at one per cycle; winVld holds with stable fields while winRdy is low.
module ipgu_win_sched #(
    parameter int IMG_SIZE = 300,
    parameter int WIN      = 20,
    parameter int STRIDE   = 10,
    parameter int ADDR_W   = 9,
    parameter int LVL_W    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              winVld,
    input  logic              winRdy,
    output logic [ADDR_W-1:0] winX,
    output logic [ADDR_W-1:0] winY,
    output logic [LVL_W-1:0]  winLvl,
    output logic              winLvlLast,
    output logic              winFrmLast,
    output logic              scaleReq,
    input  logic              scaleAck,
    output logic [ADDR_W-1:0] scaleSrc,
    output logic [ADDR_W-1:0] scaleDst,
    input  logic              scaleDone
);

    localparam int                EW        = ADDR_W + 3;
    localparam logic [EW-1:0]     WIN_E     = EW'(WIN);
    localparam logic [EW-1:0]     STEP_E    = EW'(STRIDE + WIN);
    localparam logic [EW-1:0]     FIVE_E    = EW'(5);
    localparam logic [ADDR_W-1:0] STRIDE_A  = ADDR_W'(STRIDE);
    localparam logic [ADDR_W-1:0] IMG_A     = ADDR_W'(IMG_SIZE);
    localparam bit                TOO_SMALL = (IMG_SIZE < WIN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WIN,
        S_SCALE_REQ,
        S_SCALE_WAIT,
        S_FIN
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_size;
    logic [ADDR_W-1:0] r_x;
    logic [ADDR_W-1:0] r_y;
    logic [LVL_W-1:0]  r_lvl;

    logic [EW-1:0]     w_snext_e;
    logic              w_x_end;
    logic              w_y_end;
    logic              w_lvl_end;
    logic              w_next_fits;

    // Origin tests and next level size are evaluated at the widened width so x+STRIDE+WIN and 4*S cannot wrap.
    always_comb begin
        w_x_end     = (EW'(r_x) + STEP_E) > EW'(r_size);
        w_y_end     = (EW'(r_y) + STEP_E) > EW'(r_size);
        w_lvl_end   = w_x_end && w_y_end;
        w_snext_e   = (EW'(r_size) << 2) / FIVE_E;
        w_next_fits = (w_snext_e >= WIN_E);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        winVld      = 1'b0;
        winLvlLast  = 1'b0;
        winFrmLast  = 1'b0;
        scaleReq    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = TOO_SMALL ? S_FIN : S_WIN;
                end
            end
            S_WIN: begin
                busy       = 1'b1;
                winVld     = 1'b1;
                winLvlLast = w_lvl_end;
                winFrmLast = w_lvl_end && !w_next_fits;
                if (winRdy && w_lvl_end) begin
                    w_state_nxt = w_next_fits ? S_SCALE_REQ : S_FIN;
                end
            end
            S_SCALE_REQ: begin
                busy     = 1'b1;
                scaleReq = 1'b1;
                if (scaleAck) begin
                    w_state_nxt = S_SCALE_WAIT;
                end
            end
            S_SCALE_WAIT: begin
                busy = 1'b1;
                if (scaleDone) begin
                    w_state_nxt = S_WIN;
                end
            end
            S_FIN: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Origin/level registers only move on events that are legal in the current state, so stray inputs are ignored.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_size <= '0;
            r_x    <= '0;
            r_y    <= '0;
            r_lvl  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_size <= IMG_A;
                        r_lvl  <= '0;
                        r_x    <= '0;
                        r_y    <= '0;
                    end
                end
                S_WIN: begin
                    if (winRdy) begin
                        if (w_x_end) begin
                            r_x <= '0;
                            if (!w_y_end) begin
                                r_y <= r_y + STRIDE_A;
                            end
                        end else begin
                            r_x <= r_x + STRIDE_A;
                        end
                    end
                end
                S_SCALE_WAIT: begin
                    if (scaleDone) begin
                        r_size <= w_snext_e[ADDR_W-1:0];
                        r_lvl  <= r_lvl + LVL_W'(1);
                        r_x    <= '0;
                        r_y    <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign winX     = r_x;
    assign winY     = r_y;
    assign winLvl   = r_lvl;
    assign scaleSrc = r_size;
    assign scaleDst = w_snext_e[ADDR_W-1:0];

endmodule

// File: tb/tb_ipgu_win_sched.sv
`timescale 1ns/1ps
module tb_ipgu_win_sched;
    localparam int AW   = 9;
    localparam int LW   = 4;
    localparam int NREC = 2400;

    logic       clk = 1'b0;
    logic       rst_n, start, win_rdy, scale_ack, scale_done;
    logic [1:0] sel;
    always #5 clk = ~clk;

    logic          a_busy, a_done, a_vld, a_ll, a_fl, a_req;
    logic [AW-1:0] a_x, a_y, a_src, a_dst;
    logic [LW-1:0] a_lvl;
    logic          d_busy, d_done, d_vld, d_ll, d_fl, d_req;
    logic [AW-1:0] d_x, d_y, d_src, d_dst;
    logic [LW-1:0] d_lvl;
    logic          s_busy, s_done, s_vld, s_ll, s_fl, s_req;
    logic [AW-1:0] s_x, s_y, s_src, s_dst;
    logic [LW-1:0] s_lvl;

    logic          m_busy, m_done, m_vld, m_ll, m_fl, m_req;
    logic [AW-1:0] m_x, m_y, m_src, m_dst;
    logic [LW-1:0] m_lvl;

    ipgu_win_sched #(.IMG_SIZE(40)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start && sel == 2'd0), .busy(a_busy), .done(a_done),
        .winVld(a_vld), .winRdy(win_rdy), .winX(a_x), .winY(a_y), .winLvl(a_lvl),
        .winLvlLast(a_ll), .winFrmLast(a_fl), .scaleReq(a_req), .scaleAck(scale_ack),
        .scaleSrc(a_src), .scaleDst(a_dst), .scaleDone(scale_done));

    ipgu_win_sched u_d (
        .clk(clk), .rst_n(rst_n), .start(start && sel == 2'd1), .busy(d_busy), .done(d_done),
        .winVld(d_vld), .winRdy(win_rdy), .winX(d_x), .winY(d_y), .winLvl(d_lvl),
        .winLvlLast(d_ll), .winFrmLast(d_fl), .scaleReq(d_req), .scaleAck(scale_ack),
        .scaleSrc(d_src), .scaleDst(d_dst), .scaleDone(scale_done));

    ipgu_win_sched #(.IMG_SIZE(19)) u_s (
        .clk(clk), .rst_n(rst_n), .start(start && sel == 2'd2), .busy(s_busy), .done(s_done),
        .winVld(s_vld), .winRdy(win_rdy), .winX(s_x), .winY(s_y), .winLvl(s_lvl),
        .winLvlLast(s_ll), .winFrmLast(s_fl), .scaleReq(s_req), .scaleAck(scale_ack),
        .scaleSrc(s_src), .scaleDst(s_dst), .scaleDone(scale_done));

    always_comb begin
        {m_busy, m_done, m_vld, m_ll, m_fl, m_req} = {a_busy, a_done, a_vld, a_ll, a_fl, a_req};
        {m_x, m_y, m_src, m_dst, m_lvl}            = {a_x, a_y, a_src, a_dst, a_lvl};
        if (sel == 2'd1) begin
            {m_busy, m_done, m_vld, m_ll, m_fl, m_req} = {d_busy, d_done, d_vld, d_ll, d_fl, d_req};
            {m_x, m_y, m_src, m_dst, m_lvl}            = {d_x, d_y, d_src, d_dst, d_lvl};
        end else if (sel == 2'd2) begin
            {m_busy, m_done, m_vld, m_ll, m_fl, m_req} = {s_busy, s_done, s_vld, s_ll, s_fl, s_req};
            {m_x, m_y, m_src, m_dst, m_lvl}            = {s_x, s_y, s_src, s_dst, s_lvl};
        end
    end

    int n_assert = 0;
    int n_fail   = 0;

    // Records of one frame
    logic [LW-1:0] rec_l [NREC];
    logic [AW-1:0] rec_x [NREC];
    logic [AW-1:0] rec_y [NREC];
    logic          rec_ll[NREC];
    logic          rec_fl[NREC];
    int            rec_c [NREC];
    logic [AW-1:0] rec_src[16];
    logic [AW-1:0] rec_dst[16];
    int            req_c[16];
    int            sdone_c[16];
    int  nrec, nscale, ndone, done_c, extra_done, extra_vld;
    bit  aborted, timed_out, first_busy, first_vld, first_done, done_busy;
    logic [31:0] first_pos;

    // Hand-computed expectations for IMG_SIZE=40: sizes 40/32/25/20
    int exp_x[15] = '{0, 10, 20, 0, 10, 20, 0, 10, 20, 0, 10, 0, 10, 0, 0};
    int exp_y[15] = '{0, 0, 0, 10, 10, 10, 20, 20, 20, 0, 0, 10, 10, 0, 0};
    int exp_l[15] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 2, 3};
    int exp_ll[15] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 1};
    int a_src_e[3] = '{40, 32, 25};
    int a_dst_e[3] = '{32, 25, 20};
    int a_cnt_e[4] = '{9, 4, 1, 1};
    int d_dst_e[11] = '{240, 192, 153, 122, 97, 77, 61, 48, 38, 30, 24};
    int d_src_e[11] = '{300, 240, 192, 153, 122, 97, 77, 61, 48, 38, 30};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_flags"}, {26'd0, m_busy, m_done, m_vld, m_ll, m_fl, m_req}, 32'd0);
        chk({tag, "_pos"}, {m_lvl, m_x, m_y}, 32'd0);
        chk({tag, "_scale"}, {m_src, m_dst}, 32'd0);
    endtask

    task automatic idle_cycles(input int n);
        extra_done = 0;
        extra_vld  = 0;
        repeat (n) begin
            @(negedge clk);
            if (m_done) extra_done++;
            if (m_vld) extra_vld++;
        end
    endtask

    // Drives one frame cycle by cycle at the falling edge; the scaler acks 3 cycles into a request, finishes 3 later.
    task automatic run_frame(input int budget, input bit bp, input bit inject, input bit abort_wait);
        int          req_cnt = 0;
        int          wait_cnt = 0;
        bit          in_wait = 0;
        bit          stalled = 0;
        logic [31:0] held = '0;
        nrec = 0; nscale = 0; ndone = 0; done_c = -1; aborted = 0; done_busy = 0;
        @(negedge clk);
        start = 1'b1; win_rdy = 1'b1; scale_ack = 1'b0; scale_done = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < budget; c++) begin
            if (c == 0) begin
                first_busy = m_busy; first_vld = m_vld; first_done = m_done;
                first_pos  = {8'd0, m_lvl, m_x, m_y};
            end
            if (stalled) begin
                chk("stall_vld", {31'd0, m_vld}, 32'd1);
                chk("stall_hold", {8'd0, m_lvl, m_x, m_y, m_ll, m_fl}, held);
            end
            if (m_done) begin
                ndone++; done_c = c; done_busy = m_busy;
                break;
            end
            start = 1'b0; scale_ack = 1'b0; scale_done = 1'b0;
            win_rdy = bp ? ($urandom_range(0, 9) < 3) : 1'b1;
            if (m_req) begin
                if (req_cnt == 0 && nscale < 16) req_c[nscale] = c;
                req_cnt++;
                if (req_cnt == 3) begin
                    scale_ack = 1'b1;
                    if (nscale < 16) begin
                        rec_src[nscale] = m_src; rec_dst[nscale] = m_dst;
                    end
                    nscale++; req_cnt = 0; in_wait = 1; wait_cnt = 0;
                end
            end else if (in_wait) begin
                wait_cnt++;
                if (abort_wait) begin
                    aborted = 1;
                    break;
                end
                if (wait_cnt == 3) begin
                    scale_done = 1'b1; in_wait = 0;
                    if (nscale <= 16) sdone_c[nscale-1] = c;
                end
            end
            if (inject && m_vld && (c % 7 == 3)) scale_done = 1'b1;
            if (inject && m_vld && (c % 6 == 1)) scale_ack = 1'b1;
            if (inject && m_busy && (c % 5 == 2)) start = 1'b1;
            if (m_vld && win_rdy && nrec < NREC) begin
                rec_l[nrec] = m_lvl; rec_x[nrec] = m_x; rec_y[nrec] = m_y;
                rec_ll[nrec] = m_ll; rec_fl[nrec] = m_fl; rec_c[nrec] = c;
                nrec++;
            end
            stalled = m_vld && !win_rdy;
            held    = {8'd0, m_lvl, m_x, m_y, m_ll, m_fl};
            @(negedge clk);
        end
        timed_out = (ndone == 0) && !aborted;
        start = 1'b0; scale_ack = 1'b0; scale_done = 1'b0; win_rdy = 1'b1;
    endtask

    task automatic check_a_frame(input string tag, input bit timing);
        int cnt[4] = '{0, 0, 0, 0};
        chk({tag, "_timeout"}, {31'd0, timed_out}, 32'd0);
        chk({tag, "_first_busy_vld"}, {30'd0, first_busy, first_vld}, 32'd3);
        chk({tag, "_first_pos"}, first_pos, 32'd0);
        chk({tag, "_nwin"}, nrec, 15);
        if (nrec == 15) begin
            for (int i = 0; i < 15; i++) begin
                chk($sformatf("%s_win%0d_pos", tag, i), {8'd0, rec_l[i], rec_x[i], rec_y[i]},
                    {8'd0, LW'(exp_l[i]), AW'(exp_x[i]), AW'(exp_y[i])});
                chk($sformatf("%s_win%0d_flags", tag, i), {30'd0, rec_ll[i], rec_fl[i]},
                    {30'd0, exp_ll[i] != 0, i == 14});
                if (rec_l[i] < 4) cnt[rec_l[i]]++;
            end
            for (int l = 0; l < 4; l++) chk($sformatf("%s_lvl%0d_cnt", tag, l), cnt[l], a_cnt_e[l]);
            if (timing) begin
                chk({tag, "_req_lat"}, req_c[0], rec_c[8] + 1);
                chk({tag, "_resume_lat"}, rec_c[9], sdone_c[0] + 1);
                chk({tag, "_done_lat"}, done_c, rec_c[14] + 1);
            end
        end
        chk({tag, "_nscale"}, nscale, 3);
        if (nscale == 3) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("%s_scale%0d", tag, i), {14'd0, rec_src[i], rec_dst[i]},
                    {14'd0, AW'(a_src_e[i]), AW'(a_dst_e[i])});
            end
        end
        chk({tag, "_done_busy"}, {30'd0, 1'(ndone), done_busy}, 32'd2);
    endtask

    initial begin
        int cnt0, nll, nfl, li;
        rst_n = 1'b0; start = 1'b0; win_rdy = 1'b1; scale_ack = 1'b0; scale_done = 1'b0; sel = 2'd0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = 2'(s);
            #1;
            chk_zero($sformatf("reset%0d", s));
        end
        sel = 2'd0;
        rst_n = 1'b1;

        // Level walk with the fetch path always ready; then start in the done cycle must be ignored
        run_frame(300, 0, 0, 0);
        check_a_frame("basic", 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_in_done", {30'd0, m_busy, m_vld}, 32'd0);
        idle_cycles(4);
        chk("basic_after", extra_done + extra_vld, 0);

        // Random backpressure
        run_frame(1500, 1, 0, 0);
        check_a_frame("bp", 0);
        idle_cycles(4);
        chk("bp_after", extra_done + extra_vld, 0);

        // One-cycle reset while waiting for the scaler, then a late scaleDone
        run_frame(300, 0, 0, 1);
        chk("abort_reached", {31'd0, aborted}, 32'd1);
        chk("abort_nwin", nrec, 9);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk_zero("midrst");
        scale_done = 1'b1;
        @(negedge clk);
        scale_done = 1'b0;
        chk("late_done_ignored", {30'd0, m_busy, m_vld}, 32'd0);
        idle_cycles(5);
        chk("midrst_after", extra_done + extra_vld, 0);
        run_frame(300, 0, 0, 0);
        check_a_frame("restart", 1);
        idle_cycles(3);

        // Stray start/scaleAck/scaleDone while in the window phase
        run_frame(300, 0, 1, 0);
        check_a_frame("stray", 1);
        idle_cycles(4);
        chk("stray_after", extra_done + extra_vld, 0);

        // Default 300-pixel frame
        sel = 2'd1;
        run_frame(5000, 0, 0, 0);
        chk("dflt_timeout", {31'd0, timed_out}, 32'd0);
        cnt0 = 0; nll = 0; nfl = 0;
        for (int i = 0; i < nrec; i++) begin
            if (rec_l[i] == 0) cnt0++;
            if (rec_ll[i]) nll++;
            if (rec_fl[i]) nfl++;
        end
        li = (nrec > 0) ? nrec - 1 : 0;
        chk("dflt_nwin", nrec, 2154);
        chk("dflt_lvl0_cnt", cnt0, 841);
        chk("dflt_lvl_last_cnt", nll, 12);
        chk("dflt_frm_last_cnt", nfl, 1);
        chk("dflt_last_win", {8'd0, rec_l[li], rec_x[li], rec_y[li], rec_fl[li], 1'b0},
            {8'd0, 4'd11, 9'd0, 9'd0, 1'b1, 1'b0});
        chk("dflt_nscale", nscale, 11);
        if (nscale == 11) begin
            for (int i = 0; i < 11; i++) begin
                chk($sformatf("dflt_scale%0d", i), {14'd0, rec_src[i], rec_dst[i]},
                    {14'd0, AW'(d_src_e[i]), AW'(d_dst_e[i])});
            end
        end
        chk("dflt_done_lat", done_c, rec_c[li] + 1);
        chk("dflt_done_busy", {30'd0, 1'(ndone), done_busy}, 32'd2);
        idle_cycles(3);

        // Image smaller than a window
        sel = 2'd2;
        run_frame(50, 0, 0, 0);
        chk("small_first", {29'd0, first_done, first_busy, first_vld}, 32'd4);
        chk("small_nwin_nscale", nrec + nscale, 0);
        chk("small_ndone", ndone, 1);
        idle_cycles(4);
        chk("small_after", extra_done + extra_vld, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
